regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 133 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - GPR + HI/LO register file with bypass and a pending-write scoreboard
// Optional REGFILE_SB_FLUSH_EN adds sb_flush, which clears every pending counter.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*(ADDR_W+1)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         iss_valid,
  input  logic [ADDR_W-1:0]            iss_dest,
  input  logic                         iss_hl,
  output logic                         iss_ready,
  input  logic                         wb_we,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         hl_we,
  input  logic [2*DATA_W-1:0]          hl_data,
`ifdef REGFILE_SB_FLUSH_EN
  input  logic                         sb_flush,
`endif
  output logic                         sb_err
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] r_gpr [NUM_REGS];
  logic [PEND_W-1:0] r_pend [NUM_REGS];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [PEND_W-1:0] r_pend_hl;
  logic              r_sb_err;

  logic              w_flush;
  logic              w_wb_hit;
  logic              w_gpr_full;
  logic              w_hl_full;
  logic              w_ready;
  logic              w_err_set;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic              w_inc_hl;
  logic              w_dec_hl;
  logic [PEND_W-1:0] w_pend_next [NUM_REGS];
  logic [PEND_W-1:0] w_pend_ret [NUM_REGS];
  logic [PEND_W-1:0] w_hl_next;
  logic [PEND_W-1:0] w_hl_ret;

`ifdef REGFILE_SB_FLUSH_EN
  assign w_flush = sb_flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_wb_hit   = wb_we && (wb_addr != '0);
    w_gpr_full = iss_valid && (iss_dest != '0) && (r_pend[iss_dest] == PEND_MAX)
                 && !(w_wb_hit && (wb_addr == iss_dest));
    w_hl_full  = iss_hl && (r_pend_hl == PEND_MAX) && !hl_we;
    w_ready    = !(w_gpr_full || w_hl_full || w_flush);
    w_err_set  = (w_wb_hit && (r_pend[wb_addr] == '0)) || (hl_we && (r_pend_hl == '0));
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc[i] = w_ready && iss_valid && (iss_dest == ADDR_W'(i)) && (i != 0);
      w_dec[i] = w_wb_hit && (wb_addr == ADDR_W'(i)) && (r_pend[i] != '0);
      // Busy looks only at retirement; a same-cycle issue is ordered after the operand read.
      w_pend_ret[i]  = w_flush ? '0 : r_pend[i] - PEND_W'(w_dec[i]);
      w_pend_next[i] = w_flush ? '0 : r_pend[i] + PEND_W'(w_inc[i]) - PEND_W'(w_dec[i]);
    end
    w_inc_hl  = w_ready && iss_hl;
    w_dec_hl  = hl_we && (r_pend_hl != '0);
    w_hl_ret  = w_flush ? '0 : r_pend_hl - PEND_W'(w_dec_hl);
    w_hl_next = w_flush ? '0 : r_pend_hl + PEND_W'(w_inc_hl) - PEND_W'(w_dec_hl);
  end

  assign iss_ready = w_ready;
  assign sb_err    = r_sb_err;

  always_comb begin
    logic [ADDR_W:0]   w_sel;
    logic [ADDR_W-1:0] w_idx;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_sel = rd_addr[p*(ADDR_W+1) +: (ADDR_W+1)];
      w_idx = w_sel[ADDR_W-1:0];
      if (w_sel[ADDR_W]) begin
        if (w_sel[0]) begin
          rd_data[p*DATA_W +: DATA_W] = hl_we ? hl_data[2*DATA_W-1:DATA_W] : r_hi;
        end else begin
          rd_data[p*DATA_W +: DATA_W] = hl_we ? hl_data[DATA_W-1:0] : r_lo;
        end
        rd_busy[p] = (w_hl_ret != '0);
      end else if (w_idx != '0) begin
        rd_data[p*DATA_W +: DATA_W] = (w_wb_hit && (wb_addr == w_idx)) ? wb_data : r_gpr[w_idx];
        rd_busy[p] = (w_pend_ret[w_idx] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_gpr[i]  <= '0;
        r_pend[i] <= '0;
      end
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hl <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      if (w_wb_hit) begin
        r_gpr[wb_addr] <= wb_data;
      end
      if (hl_we) begin
        r_hi <= hl_data[2*DATA_W-1:DATA_W];
        r_lo <= hl_data[DATA_W-1:0];
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pend[i] <= w_pend_next[i];
      end
      r_pend_hl <= w_hl_next;
      if (w_err_set) begin
        r_sb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed plus random checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int PMAX = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR*(AW+1)-1:0] rd_addr;
  logic [NR*DW-1:0]    rd_data;
  logic [NR-1:0]       rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_dest;
  logic                iss_hl;
  logic                iss_ready;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  logic                hl_we;
  logic [2*DW-1:0]     hl_data;
  logic                sb_flush;
  logic                sb_err;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_hl(iss_hl), .iss_ready(iss_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .hl_we(hl_we), .hl_data(hl_data),
`ifdef REGFILE_SB_FLUSH_EN
    .sb_flush(sb_flush),
`endif
    .sb_err(sb_err)
  );

  // Reference state: register contents and outstanding-write counts as plain integers.
  logic [DW-1:0] m_gpr [32];
  logic [DW-1:0] m_hi, m_lo;
  int            m_pend [32];
  int            m_pend_hl;
  bit            m_err;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = '0;
      m_pend[i] = 0;
    end
    m_hi = '0; m_lo = '0; m_pend_hl = 0; m_err = 0;
  endtask

  task automatic idle();
    iss_valid = 0; iss_dest = '0; iss_hl = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    hl_we = 0; hl_data = '0; sb_flush = 0; rd_addr = '0;
  endtask

  function automatic bit exp_ready();
    bit full_g, full_h;
    full_g = iss_valid && iss_dest != 0 && m_pend[iss_dest] == PMAX && !(wb_we && wb_addr == iss_dest);
    full_h = iss_hl && m_pend_hl == PMAX && !hl_we;
    return !(full_g || full_h || sb_flush);
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW:0] a);
    if (a[AW]) begin
      if (a[0]) return hl_we ? hl_data[2*DW-1:DW] : m_hi;
      return hl_we ? hl_data[DW-1:0] : m_lo;
    end
    if (a[AW-1:0] == 0) return '0;
    if (wb_we && wb_addr == a[AW-1:0]) return wb_data;
    return m_gpr[a[AW-1:0]];
  endfunction

  function automatic bit exp_busy(input logic [AW:0] a);
    int left;
    if (sb_flush) return 0;
    if (a[AW]) begin
      left = m_pend_hl - ((hl_we && m_pend_hl > 0) ? 1 : 0);
      return left != 0;
    end
    if (a[AW-1:0] == 0) return 0;
    left = m_pend[a[AW-1:0]] - ((wb_we && wb_addr == a[AW-1:0] && m_pend[a[AW-1:0]] > 0) ? 1 : 0);
    return left != 0;
  endfunction

  task automatic compare_outputs();
    logic [AW:0] a;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*(AW+1) +: (AW+1)];
      check($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], exp_data(a));
      check($sformatf("rd_busy%0d", p), rd_busy[p], exp_busy(a));
    end
    check("iss_ready", iss_ready, exp_ready());
    check("sb_err", sb_err, m_err);
  endtask

  task automatic model_update();
    bit rdy;
    rdy = exp_ready();
    if (wb_we && wb_addr != 0 && m_pend[wb_addr] == 0) m_err = 1;
    if (hl_we && m_pend_hl == 0) m_err = 1;
    if (sb_flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_pend_hl = 0;
    end else begin
      if (wb_we && wb_addr != 0 && m_pend[wb_addr] > 0) m_pend[wb_addr]--;
      if (hl_we && m_pend_hl > 0) m_pend_hl--;
      if (rdy && iss_valid && iss_dest != 0) m_pend[iss_dest]++;
      if (rdy && iss_hl) m_pend_hl++;
    end
    if (wb_we && wb_addr != 0) m_gpr[wb_addr] = wb_data;
    if (hl_we) begin
      m_hi = hl_data[2*DW-1:DW];
      m_lo = hl_data[DW-1:0];
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    idle();
    model_reset();
    #1;
    settle();
    check("rst_ready", iss_ready, 1);
    @(posedge clk); #1;
    rst = 1;

    for (int k = 0; k < 4; k++) begin
      rd_addr = {6'(k * 9), 6'(6'b100000 | k)};
      settle();
      check("rst_data0", rd_data[DW-1:0], 0);
      check("rst_busy", rd_busy, 0);
      advance();
    end

    // Scoreboard on r7
    idle(); iss_valid = 1; iss_dest = 7; rd_addr = 6'd7;
    settle(); check("iss7_busy_same", rd_busy[0], 0); advance();
    idle(); rd_addr = 6'd7;
    settle(); check("r7_busy", rd_busy[0], 1); advance();
    idle(); wb_we = 1; wb_addr = 7; wb_data = 32'h12; rd_addr = 6'd7;
    settle(); check("r7_wb_busy", rd_busy[0], 0); check("r7_wb_data", rd_data[DW-1:0], 32'h12); advance();
    idle(); iss_valid = 1; iss_dest = 0; rd_addr = 6'd0;
    settle(); check("r0_data", rd_data[DW-1:0], 0); advance();
    idle(); rd_addr = 6'd0;
    settle(); check("r0_busy", rd_busy[0], 0); advance();

    // Saturation on r3
    for (int k = 0; k < 3; k++) begin
      idle(); iss_valid = 1; iss_dest = 3;
      settle(); check("sat_ready", iss_ready, 1); advance();
    end
    idle(); iss_valid = 1; iss_dest = 3;
    settle(); check("sat_full", iss_ready, 0); advance();
    idle(); iss_valid = 1; iss_dest = 3; wb_we = 1; wb_addr = 3; wb_data = 32'h33;
    settle(); check("sat_wb_ready", iss_ready, 1); advance();
    idle(); iss_valid = 1; iss_dest = 3;
    settle(); check("sat_still_full", iss_ready, 0); advance();
    for (int k = 0; k < 3; k++) begin
      idle(); wb_we = 1; wb_addr = 3; wb_data = 32'(k); rd_addr = 6'd3;
      settle(); check("drain_busy", rd_busy[0], (k == 2) ? 0 : 1); advance();
    end

    // HI/LO
    idle(); iss_hl = 1; advance();
    idle(); rd_addr = {6'b100000, 6'b100001};
    settle(); check("hl_busy", rd_busy, 2'b11); advance();
    idle(); hl_we = 1; hl_data = {32'hAAAA0000, 32'h0000BBBB}; rd_addr = {6'b100000, 6'b100001};
    settle();
    check("hi_byp", rd_data[DW-1:0], 32'hAAAA0000);
    check("lo_byp", rd_data[2*DW-1:DW], 32'h0000BBBB);
    check("hl_wb_busy", rd_busy, 0);
    check("no_err_yet", sb_err, 0);
    advance();

    // Bypass of an unscheduled writeback, which also trips sb_err
    idle(); wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rd_addr = 6'd5;
    settle(); check("byp5", rd_data[DW-1:0], 32'hDEADBEEF); advance();
    idle(); rd_addr = 6'd5;
    settle(); check("store5", rd_data[DW-1:0], 32'hDEADBEEF); check("err_set", sb_err, 1); advance();
    idle(); wb_we = 1; wb_addr = 9; wb_data = 32'h99; advance();
    idle(); settle(); check("err_sticky", sb_err, 1); advance();

`ifdef REGFILE_SB_FLUSH_EN
    for (int k = 0; k < 2; k++) begin
      idle(); iss_valid = 1; iss_dest = 4; settle(); advance();
    end
    idle(); sb_flush = 1; iss_valid = 1; iss_dest = 4; rd_addr = 6'd4;
    settle(); check("flush_ready", iss_ready, 0); advance();
    idle(); rd_addr = 6'd4;
    settle(); check("flush_busy", rd_busy[0], 0); advance();
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [AW:0] a [NR];
      iss_valid = $urandom_range(0, 1);
      iss_dest  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      iss_hl    = ($urandom_range(0, 3) == 0);
      wb_we     = $urandom_range(0, 1);
      wb_addr   = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      hl_we     = ($urandom_range(0, 4) == 0);
      hl_data   = {$urandom, $urandom};
`ifdef REGFILE_SB_FLUSH_EN
      sb_flush  = ($urandom_range(0, 31) == 0);
`else
      sb_flush  = 0;
`endif
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 3) == 0) a[p] = {1'b1, AW'($urandom)};
        else a[p] = {1'b0, AW'($urandom_range(0, 7))};
        rd_addr[p*(AW+1) +: (AW+1)] = a[p];
      end
      if (i == 1500) begin
        rst = 0;
        model_reset();
        #1;
        settle();
        @(posedge clk); #1;
        rst = 1;
      end else begin
        settle();
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
